al4s3b_fpga_wb_initiator: RTL and testbench

Wishbone bus initiator that turns single register-access requests, delivered over a valid/ready handshake, into classic single-cycle Wishbone read and write transfers. It then returns the read data or an error over a second valid/ready handshake. It sits between a command source (host bridge or command decoder) and the FPGA's Wishbone register responders, such as the GPIO register block. It drives the same bus signals those responders consume. A timeout guards against responders that never assert ACK.

---
 rtl/al4s3b_fpga_wb_pkg.sv | 18 +
 rtl/al4s3b_fpga_wb_timeout_ctr.sv | 48 ++++
 rtl/al4s3b_fpga_wb_initiator.sv | 176 +++++++++++++++++
 tb/tb_al4s3b_fpga_wb_initiator.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/al4s3b_fpga_wb_pkg.sv
// Shared definitions for the AL4S3B FPGA Wishbone initiator.
//
// Contents:
//   wb_state_e           - initiator FSM encoding (IDLE/BUS/RESP)
//   TIMEOUT_DATA_DEFAULT - response data returned when a responder never ACKs
//   DEFAULT_REG_VALUE    - value responder models return for unmapped reads
package al4s3b_fpga_wb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } wb_state_e;

  localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;
  localparam logic [31:0] DEFAULT_REG_VALUE    = 32'hDEFF_ABAC;

endpackage

// File: rtl/al4s3b_fpga_wb_timeout_ctr.sv
// Clearable saturating cycle counter used to bound how long a Wishbone cycle
// may wait for ACK.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset, count returns to 0
//   clear    - synchronous clear to 0 (wins over inc)
//   inc      - advance the count by one; holds at all-ones instead of wrapping
//   count    - current count
//   terminal - high while count equals LIMIT-1 (last permitted wait cycle)
module al4s3b_fpga_wb_timeout_ctr #(
  parameter  int unsigned LIMIT = 255,
  localparam int unsigned WIDTH = $clog2(LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  localparam logic [WIDTH-1:0] MaxCount  = '1;
  localparam logic [WIDTH-1:0] TermCount = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != MaxCount)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign terminal = (count_q == TermCount);

endmodule

// File: rtl/al4s3b_fpga_wb_initiator.sv
// Wishbone initiator: converts single register-access requests (valid/ready)
// into classic single-transfer Wishbone cycles and returns read data or a
// timeout error over a second valid/ready channel.
//
// Ports:
//   WBm_CLK_i / WBm_RST_n_i        - clock and asynchronous active-low reset
//   REQ_VALID_i / REQ_READY_o      - request handshake
//   REQ_WE_i/ADR_i/BE_i/DAT_i      - request fields, latched on acceptance
//   RSP_VALID_o / RSP_READY_i      - response handshake
//   RSP_DAT_o / RSP_ERR_o          - read data (0 for writes) / timeout flag
//   WBm_ADR/CYC/STB/WE/BYTE_STB/DAT_o, WBm_DAT_i, WBm_ACK_i - Wishbone bus
//   BUSY_o                         - a transfer or its response is in flight
//
// Every output is a flop; next-state values are derived from the next FSM
// state so no input reaches an output combinationally.
module al4s3b_fpga_wb_initiator
  import al4s3b_fpga_wb_pkg::*;
#(
  parameter int unsigned ADDRWIDTH      = 17,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEFAULT
) (
  input  logic                 WBm_CLK_i,
  input  logic                 WBm_RST_n_i,

  input  logic                 REQ_VALID_i,
  output logic                 REQ_READY_o,
  input  logic                 REQ_WE_i,
  input  logic [ADDRWIDTH-1:0] REQ_ADR_i,
  input  logic [3:0]           REQ_BE_i,
  input  logic [31:0]          REQ_DAT_i,

  output logic                 RSP_VALID_o,
  input  logic                 RSP_READY_i,
  output logic [31:0]          RSP_DAT_o,
  output logic                 RSP_ERR_o,

  output logic [ADDRWIDTH-1:0] WBm_ADR_o,
  output logic                 WBm_CYC_o,
  output logic                 WBm_STB_o,
  output logic                 WBm_WE_o,
  output logic [3:0]           WBm_BYTE_STB_o,
  output logic [31:0]          WBm_DAT_o,
  input  logic [31:0]          WBm_DAT_i,
  input  logic                 WBm_ACK_i,

  output logic                 BUSY_o
);

  localparam int unsigned TimerWidth = $clog2(TIMEOUT_CYCLES + 1);

  wb_state_e state_q, state_d;

  logic                 req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_dat_q, rsp_dat_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [ADDRWIDTH-1:0] adr_q, adr_d;
  logic                 cyc_q, cyc_d;
  logic                 we_q, we_d;
  logic [3:0]           be_q, be_d;
  logic [31:0]          dat_q, dat_d;
  logic                 busy_q, busy_d;

  logic                  timer_clear;
  logic                  timer_inc;
  logic                  timer_done;
  logic [TimerWidth-1:0] timer_count;

  al4s3b_fpga_wb_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk      (WBm_CLK_i),
    .rst_n    (WBm_RST_n_i),
    .clear    (timer_clear),
    .inc      (timer_inc),
    .count    (timer_count),
    .terminal (timer_done)
  );

  always_comb begin
    state_d     = state_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    adr_d       = adr_q;
    we_d        = we_q;
    be_d        = be_q;
    dat_d       = dat_q;
    timer_clear = 1'b0;
    timer_inc   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // req_ready_q is the registered READY the requester actually sees.
        if (REQ_VALID_i && req_ready_q) begin
          adr_d       = REQ_ADR_i;
          we_d        = REQ_WE_i;
          be_d        = REQ_BE_i;
          dat_d       = REQ_DAT_i;
          timer_clear = 1'b1;
          state_d     = StBus;
        end
      end
      StBus: begin
        // ACK takes priority over a timeout landing on the same edge.
        if (WBm_ACK_i) begin
          rsp_dat_d = we_q ? 32'h0 : WBm_DAT_i;
          rsp_err_d = 1'b0;
          state_d   = StResp;
        end else if (timer_done) begin
          rsp_dat_d = TIMEOUT_DATA;
          rsp_err_d = 1'b1;
          state_d   = StResp;
        end else begin
          timer_inc = 1'b1;
        end
      end
      StResp: begin
        if (RSP_READY_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // READY returns one edge after the response handshake, so a request can
    // never be taken on the edge that completes a response.
    req_ready_d = (state_d == StIdle);
    cyc_d       = (state_d == StBus);
    rsp_valid_d = (state_d == StResp);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge WBm_CLK_i or negedge WBm_RST_n_i) begin
    if (!WBm_RST_n_i) begin
      state_q     <= StIdle;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= 32'h0;
      rsp_err_q   <= 1'b0;
      adr_q       <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= 4'h0;
      dat_q       <= 32'h0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      adr_q       <= adr_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      be_q        <= be_d;
      dat_q       <= dat_d;
      busy_q      <= busy_d;
    end
  end

  assign REQ_READY_o    = req_ready_q;
  assign RSP_VALID_o    = rsp_valid_q;
  assign RSP_DAT_o      = rsp_dat_q;
  assign RSP_ERR_o      = rsp_err_q;
  assign WBm_ADR_o      = adr_q;
  assign WBm_CYC_o      = cyc_q;
  assign WBm_STB_o      = cyc_q;
  assign WBm_WE_o       = we_q;
  assign WBm_BYTE_STB_o = be_q;
  assign WBm_DAT_o      = dat_q;
  assign BUSY_o         = busy_q;

endmodule

// File: tb/tb_al4s3b_fpga_wb_initiator.sv
// Directed self-checking bench for al4s3b_fpga_wb_initiator with a small
// Wishbone responder model (registered ACK, never-ACK or zero-wait modes).
module tb_al4s3b_fpga_wb_initiator;
  import al4s3b_fpga_wb_pkg::*;

  localparam int unsigned AW = 17;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_adr;
  logic [3:0]    req_be;
  logic [31:0]   req_dat;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_dat;
  logic          rsp_err;
  logic [AW-1:0] wb_adr;
  logic          wb_cyc;
  logic          wb_stb;
  logic          wb_we;
  logic [3:0]    wb_be;
  logic [31:0]   wb_wdat;
  logic [31:0]   wb_rdat;
  logic          wb_ack;
  logic          busy;

  int tests;
  int fails;
  int cyc_num;

  // Responder model: 0 = registered ACK, 1 = never ACK, 2 = zero-wait ACK
  int          mode;
  logic        force_ack;
  logic        ack_r;
  logic [31:0] zw_data;
  logic [31:0] regs [0:2];
  logic        mapped;
  logic [1:0]  idx;

  al4s3b_fpga_wb_initiator #(
    .ADDRWIDTH      (AW),
    .TIMEOUT_CYCLES (8),
    .TIMEOUT_DATA   (32'hDEAD_BEEF)
  ) dut (
    .WBm_CLK_i      (clk),
    .WBm_RST_n_i    (rst_n),
    .REQ_VALID_i    (req_valid),
    .REQ_READY_o    (req_ready),
    .REQ_WE_i       (req_we),
    .REQ_ADR_i      (req_adr),
    .REQ_BE_i       (req_be),
    .REQ_DAT_i      (req_dat),
    .RSP_VALID_o    (rsp_valid),
    .RSP_READY_i    (rsp_ready),
    .RSP_DAT_o      (rsp_dat),
    .RSP_ERR_o      (rsp_err),
    .WBm_ADR_o      (wb_adr),
    .WBm_CYC_o      (wb_cyc),
    .WBm_STB_o      (wb_stb),
    .WBm_WE_o       (wb_we),
    .WBm_BYTE_STB_o (wb_be),
    .WBm_DAT_o      (wb_wdat),
    .WBm_DAT_i      (wb_rdat),
    .WBm_ACK_i      (wb_ack),
    .BUSY_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_num <= cyc_num + 1;

  assign mapped  = (wb_adr[AW-1:4] == '0) && (wb_adr[3:2] != 2'd3);
  assign idx     = wb_adr[3:2];
  assign wb_ack  = ((mode == 2) ? (wb_cyc & wb_stb) : ack_r) | force_ack;
  assign wb_rdat = (mode == 2) ? zw_data : (mapped ? regs[idx] : DEFAULT_REG_VALUE);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r   <= 1'b0;
      regs[0] <= 32'h0;
      regs[1] <= 32'h0;
      regs[2] <= 32'h0;
    end else begin
      ack_r <= (mode == 0) && wb_cyc && wb_stb && !ack_r;
      if ((mode == 0) && wb_cyc && wb_stb && !ack_r && wb_we && mapped) begin
        for (int b = 0; b < 4; b++) begin
          if (wb_be[b]) regs[idx][b*8 +: 8] <= wb_wdat[b*8 +: 8];
        end
      end
    end
  end

  // Issues one request from a negedge and observes it at each negedge.
  // lat = edges after the accept edge until RSP_VALID is seen (-1 on stall).
  task automatic run_txn(input logic we, input logic [AW-1:0] adr, input logic [3:0] be,
                         input logic [31:0] dat, input int force_at, input bit hold_rsp,
                         output int cyc_cnt, output int stb_cnt, output int lat,
                         output logic [31:0] rdat, output logic rerr,
                         output logic [3:0] be_seen);
    int n;
    cyc_cnt   = 0;
    stb_cnt   = 0;
    lat       = -1;
    rdat      = 32'h0;
    rerr      = 1'b0;
    be_seen   = 4'h0;
    rsp_ready = !hold_rsp;
    req_we    = we;
    req_adr   = adr;
    req_be    = be;
    req_dat   = dat;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (rsp_valid) begin
        force_ack = 1'b0;
        rdat = rsp_dat;
        rerr = rsp_err;
        lat  = i;
        break;
      end
      if (wb_cyc) begin
        cyc_cnt++;
        be_seen = wb_be;
      end
      if (wb_stb) stb_cnt++;
      force_ack = (force_at != 0) && (cyc_cnt == force_at);
      @(negedge clk);
    end
    force_ack = 1'b0;
    if (!hold_rsp && lat >= 0) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_req_ready: got %b expected 0", req_ready);
    end
    tests++;
    if ({wb_cyc, wb_stb, rsp_valid, busy, rsp_err} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 00000", {wb_cyc, wb_stb, rsp_valid, busy, rsp_err});
    end
    tests++;
    if ({rsp_dat, wb_wdat, wb_adr, wb_be, wb_we} !== '0) begin
      fails++;
      $display("FAIL reset_data: rsp_dat %h wdat %h adr %h be %b we %b expected all 0",
               rsp_dat, wb_wdat, wb_adr, wb_be, wb_we);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_write();
    int c, s, l;
    logic [31:0] d;
    logic e;
    logic [3:0] b;
    run_txn(1'b1, 17'h004, 4'b0001, 32'h0000_00A5, 0, 0, c, s, l, d, e, b);
    tests++;
    if (c !== 2 || s !== 2) begin
      fails++;
      $display("FAIL write_cyc_len: cyc %0d stb %0d expected 2 2", c, s);
    end
    tests++;
    if (b !== 4'b0001) begin
      fails++;
      $display("FAIL write_byte_stb: got %b expected 0001", b);
    end
    tests++;
    if (regs[1] !== 32'h0000_00A5) begin
      fails++;
      $display("FAIL write_model_reg: got %h expected 000000a5", regs[1]);
    end
    tests++;
    if (d !== 32'h0 || e !== 1'b0 || l !== 2) begin
      fails++;
      $display("FAIL write_rsp: dat %h err %b lat %0d expected 0 0 2", d, e, l);
    end
  endtask

  task automatic test_read();
    int c, s, l;
    logic [31:0] d;
    logic e;
    logic [3:0] b;
    run_txn(1'b0, 17'h00C, 4'hF, 32'h0, 0, 0, c, s, l, d, e, b);
    tests++;
    if (d !== 32'hDEFF_ABAC || e !== 1'b0) begin
      fails++;
      $display("FAIL read_unmapped: dat %h err %b expected deffabac 0", d, e);
    end
    tests++;
    if (l !== 2) begin
      fails++;
      $display("FAIL read_latency: got %0d expected 2", l);
    end
    run_txn(1'b0, 17'h004, 4'hF, 32'h0, 0, 0, c, s, l, d, e, b);
    tests++;
    if (d !== 32'h0000_00A5 || e !== 1'b0) begin
      fails++;
      $display("FAIL read_back: dat %h err %b expected 000000a5 0", d, e);
    end
  endtask

  task automatic test_timeout();
    int c, s, l;
    logic [31:0] d;
    logic e;
    logic [3:0] b;
    mode = 1;
    run_txn(1'b0, 17'h010, 4'hF, 32'h0, 0, 0, c, s, l, d, e, b);
    tests++;
    if (c !== 8 || l !== 8) begin
      fails++;
      $display("FAIL timeout_cyc_len: cyc %0d lat %0d expected 8 8", c, l);
    end
    tests++;
    if (d !== 32'hDEAD_BEEF || e !== 1'b1) begin
      fails++;
      $display("FAIL timeout_rsp: dat %h err %b expected deadbeef 1", d, e);
    end
    tests++;
    if (wb_adr !== 17'h010 || wb_cyc !== 1'b0) begin
      fails++;
      $display("FAIL timeout_adr_hold: adr %h cyc %b expected 010 0", wb_adr, wb_cyc);
    end
    run_txn(1'b0, 17'h00C, 4'hF, 32'h0, 8, 0, c, s, l, d, e, b);
    tests++;
    if (c !== 8 || e !== 1'b0 || d !== 32'hDEFF_ABAC) begin
      fails++;
      $display("FAIL timeout_ack_wins: cyc %0d err %b dat %h expected 8 0 deffabac", c, e, d);
    end
    mode = 0;
  endtask

  task automatic test_back_to_back();
    int c, s, l;
    logic [31:0] d;
    logic e;
    logic [3:0] b;
    int rise_t[$];
    logic prev;
    int n;
    run_txn(1'b0, 17'h004, 4'hF, 32'h0, 0, 1, c, s, l, d, e, b);
    tests++;
    if (rsp_valid !== 1'b1 || d !== 32'h0000_00A5) begin
      fails++;
      $display("FAIL bp_first_rsp: valid %b dat %h expected 1 000000a5", rsp_valid, d);
    end
    req_we    = 1'b0;
    req_adr   = 17'h008;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b1 || rsp_dat !== 32'h0000_00A5 || rsp_err !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold_rsp[%0d]: valid %b dat %h err %b expected 1 000000a5 0",
                 i, rsp_valid, rsp_dat, rsp_err);
      end
      tests++;
      if (req_ready !== 1'b0 || wb_cyc !== 1'b0) begin
        fails++;
        $display("FAIL bp_no_accept[%0d]: ready %b cyc %b expected 0 0", i, req_ready, wb_cyc);
      end
    end
    rsp_ready = 1'b1;
    prev = wb_cyc;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (wb_cyc && !prev) rise_t.push_back(cyc_num);
      prev = wb_cyc;
    end
    req_valid = 1'b0;
    tests++;
    if (rise_t.size() < 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d cycles expected at least 3", rise_t.size());
    end else if ((rise_t[1] - rise_t[0]) !== 4 || (rise_t[2] - rise_t[1]) !== 4) begin
      fails++;
      $display("FAIL b2b_spacing: got %0d %0d expected 4 4",
               rise_t[1] - rise_t[0], rise_t[2] - rise_t[1]);
    end
    n = 0;
    while ((busy || !req_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_drain: busy %b ready %b expected 0 1", busy, req_ready);
    end
  endtask

  task automatic test_reset_mid_bus();
    int stale;
    rsp_ready = 1'b1;
    req_we    = 1'b0;
    req_adr   = 17'h004;
    req_be    = 4'hF;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (wb_cyc !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre_cyc: got %b expected 1", wb_cyc);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({wb_cyc, wb_stb, rsp_valid, busy, req_ready} !== 5'b0) begin
      fails++;
      $display("FAIL rst_async: cyc/stb/valid/busy/ready got %b expected 00000",
               {wb_cyc, wb_stb, rsp_valid, busy, req_ready});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid || wb_cyc) stale++;
    end
    tests++;
    if (stale !== 0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_no_stale: stale %0d ready %b expected 0 1", stale, req_ready);
    end
  endtask

  task automatic test_zero_wait();
    int c, s, l;
    logic [31:0] d;
    logic e;
    logic [3:0] b;
    int spur;
    mode    = 2;
    zw_data = 32'h1234_5678;
    run_txn(1'b0, 17'h000, 4'hF, 32'h0, 0, 0, c, s, l, d, e, b);
    tests++;
    if (c !== 1 || l !== 1) begin
      fails++;
      $display("FAIL zw_cyc_len: cyc %0d lat %0d expected 1 1", c, l);
    end
    tests++;
    if (d !== 32'h1234_5678 || e !== 1'b0) begin
      fails++;
      $display("FAIL zw_rdata: dat %h err %b expected 12345678 0", d, e);
    end
    mode = 0;
    spur = 0;
    for (int i = 0; i < 6; i++) begin
      force_ack = (i < 3);
      @(negedge clk);
      if (rsp_valid || wb_cyc || busy) spur++;
    end
    force_ack = 1'b0;
    tests++;
    if (spur !== 0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL zw_stray_ack: spurious %0d ready %b expected 0 1", spur, req_ready);
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    cyc_num   = 0;
    mode      = 0;
    force_ack = 1'b0;
    zw_data   = 32'h0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_adr   = '0;
    req_be    = 4'h0;
    req_dat   = 32'h0;
    rsp_ready = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_back_to_back();
    test_reset_mid_bus();
    test_zero_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
